// File: rtl/tpu_compute_ctrl.sv
// tpu_compute_ctrl: sequences one systolic-array compute per start pulse.
//   A start accepted in IDLE runs COMPUTE for 3*DIM-2 cycles, during which
//   sa_en is high, and feed_en is high for the first 2*DIM-1 of them. A
//   single DONE cycle follows and the FSM then returns to IDLE. abort cancels
//   a compute with no done pulse. A start that arrives while busy is
//   dropped and reported on start_drop.
// Optional feature: define TPU_CTRL_IRQ_EN to add a sticky irq output, set
//   the cycle after done and cleared by irq_clr. When both coincide, set wins.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle start pulse (MMIO write to 0x400)
//   abort        synchronous cancel of an in-flight compute
//   feed_en      A/B operand memory shift enable
//   sa_en        systolic array MAC/propagate enable
//   busy         compute in flight (COMPUTE or DONE)
//   done         one-cycle completion pulse
//   start_drop   one-cycle pulse, start was ignored because busy
//   irq, irq_clr (TPU_CTRL_IRQ_EN only) completion interrupt and its clear
module tpu_compute_ctrl #(
    parameter int unsigned DIM  = 8,
    parameter int unsigned CNTW = $clog2(3*DIM)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic feed_en,
    output logic sa_en,
    output logic busy,
    output logic done,
    output logic start_drop
`ifdef TPU_CTRL_IRQ_EN
    ,
    output logic irq,
    input  logic irq_clr
`endif
);

    localparam int unsigned CNT_LAST  = 3*DIM - 3;
    localparam int unsigned FEED_LAST = 2*DIM - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNTW-1:0]   cnt, cnt_d;
    logic              feed_en_d, sa_en_d, busy_d, done_d, start_drop_d;

    // Next state, next counter, and output values decoded from the next state
    // so the registered outputs are Moore functions of the registered state.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        start_drop_d = 1'b0;
        case (state)
            IDLE: begin
                // abort beats a coincident start
                if (start && !abort) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                start_drop_d = start;
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CNTW'(CNT_LAST)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            DONE: begin
                start_drop_d = start;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        sa_en_d   = (state_d == COMPUTE);
        feed_en_d = (state_d == COMPUTE) && (cnt_d <= CNTW'(FEED_LAST));
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            feed_en    <= 1'b0;
            sa_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            feed_en    <= feed_en_d;
            sa_en      <= sa_en_d;
            busy       <= busy_d;
            done       <= done_d;
            start_drop <= start_drop_d;
        end
    end

`ifdef TPU_CTRL_IRQ_EN
    // Sticky completion interrupt; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tpu_compute_ctrl.sv
// Self-checking bench for tpu_compute_ctrl: directed latency/drop/abort/reset
// scenarios with literal expectations, then randomized start/abort/reset
// traffic checked every cycle against a cycle-count model.
module tb_tpu_compute_ctrl;

    localparam int DIM    = 8;
    localparam int LAST_K = 3*DIM - 1;   // cycle index of the done pulse

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic irq_clr = 1'b0;
    logic feed_en, sa_en, busy, done, start_drop;
`ifdef TPU_CTRL_IRQ_EN
    logic irq;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    tpu_compute_ctrl #(.DIM(DIM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .feed_en    (feed_en),
        .sa_en      (sa_en),
        .busy       (busy),
        .done       (done),
        .start_drop (start_drop)
`ifdef TPU_CTRL_IRQ_EN
        ,
        .irq        (irq),
        .irq_clr    (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mk counts cycles since an accepted start (0 = idle).
    // Cycles 1..3*DIM-2 compute, cycle 3*DIM-1 is done.
    int mk = 0;
    bit mdrop = 1'b0;
    bit mirq = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk    <= 0;
            mdrop <= 1'b0;
            mirq  <= 1'b0;
        end else begin
            mdrop <= start && (mk != 0);
            if (mk == LAST_K)   mirq <= 1'b1;
            else if (irq_clr)   mirq <= 1'b0;
            if (mk == 0)             mk <= (start && !abort) ? 1 : 0;
            else if (mk < LAST_K)    mk <= abort ? 0 : mk + 1;
            else                     mk <= 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("sa_en",      int'(sa_en),      int'(mk >= 1 && mk <= 3*DIM-2));
            check("feed_en",    int'(feed_en),    int'(mk >= 1 && mk <= 2*DIM-1));
            check("busy",       int'(busy),       int'(mk != 0));
            check("done",       int'(done),       int'(mk == LAST_K));
            check("start_drop", int'(start_drop), int'(mdrop));
`ifdef TPU_CTRL_IRQ_EN
            check("irq",        int'(irq),        int'(mirq));
`endif
        end
    end

    // Drive inputs for the next edge, then move to just after the following negedge
    task automatic tick(input logic s, input logic a, input logic c);
        start   = s;
        abort   = a;
        irq_clr = c;
        @(negedge clk);
        #1;
    endtask

    int sa_c, feed_c, busy_c, done_c, done_at, drop_at;

    task automatic clr_stats();
        sa_c = 0; feed_c = 0; busy_c = 0; done_c = 0; done_at = -1; drop_at = -1;
    endtask

    task automatic sample(input int i);
        sa_c   += int'(sa_en);
        feed_c += int'(feed_en);
        busy_c += int'(busy);
        if (done) begin done_c++; done_at = i; end
        if (start_drop) drop_at = i;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick(0, 0, 0);

        // Plain compute: start sampled at edge T
        clr_stats();
        tick(1, 0, 0);
        for (int i = 1; i <= 26; i++) begin
            sample(i);
            tick(0, 0, 0);
        end
        check("plain_sa_cycles",   sa_c,    22);
        check("plain_feed_cycles", feed_c,  15);
        check("plain_busy_cycles", busy_c,  23);
        check("plain_done_at",     done_at, 23);
        check("plain_done_count",  done_c,  1);

        // Start re-pulsed mid-compute is dropped
        clr_stats();
        tick(1, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            sample(i);
            tick(i == 5, 0, 0);
        end
        check("drop_at",         drop_at, 6);
        check("drop_done_at",    done_at, 23);
        check("drop_done_count", done_c,  1);

        // Abort at T+10, restart at T+14
        clr_stats();
        tick(1, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            sample(i);
            if (i == 11) begin
                check("abort_sa_off",   int'(sa_en), 0);
                check("abort_busy_off", int'(busy),  0);
            end
            tick(i == 14, i == 10, 0);
        end
        check("abort_done_at",    done_at, 37);
        check("abort_done_count", done_c,  1);

        // Reset asserted at T+8 for two cycles
        clr_stats();
        tick(1, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            sample(i);
            if (i == 8) begin
                rst_n = 1'b0;
                #1;
                check("rst_sa_en",   int'(sa_en),   0);
                check("rst_feed_en", int'(feed_en), 0);
                check("rst_busy",    int'(busy),    0);
            end
            if (i == 10) rst_n = 1'b1;
            tick(0, 0, 0);
        end
        check("rst_done_count", done_c, 0);

        // Start during the DONE cycle, then a new start at T+25
        clr_stats();
        tick(1, 0, 0);
        for (int i = 1; i <= 50; i++) begin
            sample(i);
            if (i == 24) check("done_start_busy", int'(busy), 0);
            tick(i == 23 || i == 25, 0, 0);
        end
        check("done_drop_at",    drop_at, 24);
        check("done_done_at",    done_at, 48);
        check("done_done_count", done_c,  2);

`ifdef TPU_CTRL_IRQ_EN
        // irq set after done, cleared at T+30; then clear coinciding with set
        tick(1, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            if (i == 24) check("irq_set",   int'(irq), 1);
            if (i == 31) check("irq_clear", int'(irq), 0);
            tick(0, 0, i == 30);
        end
        tick(1, 0, 0);
        for (int i = 1; i <= 26; i++) begin
            if (i == 24) check("irq_set_wins", int'(irq), 1);
            tick(0, 0, i == 23);
        end
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick(($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_compute_ctrl.md
TPU_COMPUTE_CTRL -- requirements
Module: tpu_compute_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, systolic array dimension (rows = cols).
REQ-002 SHALL have parameter CNTW, default $clog2(3*DIM), compute-phase cycle counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse from MMIO decode (write to 0x400).
REQ-006 SHALL have port abort  input  1  synchronous cancel of an in-flight compute.
REQ-007 SHALL have port feed_en  output  1  shift enable to A and B operand memories.
REQ-008 SHALL have port sa_en  output  1  systolic array MAC/propagate enable.
REQ-009 SHALL have port busy  output  1  high while a compute is in flight; MMIO writes to A/B/C are blocked while high.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a compute completes.
REQ-011 SHALL have port start_drop  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-012 SHALL implement states IDLE, COMPUTE, DONE.
REQ-013 All outputs SHALL be Moore decodes of registered state and counter; there is no combinational path from start or abort to any output.
REQ-014 IDLE: on start=1 SHALL go to COMPUTE with cnt=0; otherwise stay in IDLE.
REQ-015 COMPUTE: cnt SHALL increment by 1 each cycle; at cnt=3*DIM-3 SHALL go to DONE and clear cnt to 0.
REQ-016 feed_en SHALL be 1 in COMPUTE when cnt <= 2*DIM-2 (2*DIM-1 cycles), else 0.
REQ-017 sa_en SHALL be 1 for every COMPUTE cycle (3*DIM-2 cycles), else 0.
REQ-018 busy SHALL be 1 in COMPUTE and DONE, 0 in IDLE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: with start sampled at edge T, sa_en SHALL be high for cycles T+1..T+3*DIM-2; done SHALL be high in cycle T+3*DIM-1.
REQ-021 start in COMPUTE SHALL be ignored, with start_drop=1 in the following cycle.
REQ-022 start in DONE SHALL likewise be ignored and SHALL raise start_drop; DONE still returns to IDLE.
REQ-023 abort=1 in COMPUTE SHALL force IDLE with cnt=0 next cycle, and done SHALL NOT pulse.
REQ-024 abort=1 in IDLE or DONE SHALL have no effect.
REQ-025 When start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 cnt SHALL never exceed 3*DIM-3; it SHALL NOT wrap in normal operation.

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE, cnt=0, feed_en=0, sa_en=0, busy=0, done=0, start_drop=0.
REQ-028 Reset asserted mid-COMPUTE SHALL abandon the operation; after release the FSM SHALL wait in IDLE for a new start.

Configuration
REQ-029 Macro TPU_CTRL_IRQ_EN, when defined, SHALL add port irq output 1 and port irq_clr input 1.
REQ-030 With TPU_CTRL_IRQ_EN defined:
- irq SHALL set on the cycle after done.
- irq SHALL hold until irq_clr=1 is sampled.
- If set and clear coincide, set SHALL win.
- irq SHALL reset to 0.
REQ-031 Without TPU_CTRL_IRQ_EN, irq and irq_clr SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 DIM=8, start pulse at edge T -> sa_en high for T+1..T+22; feed_en high for T+1..T+15; done high only in T+23; busy high T+1..T+23.
REQ-033 start re-pulsed at T+5 -> start_drop=1 in T+6; done still at T+23 only; no second compute.
REQ-034 abort at cycle T+10 -> IDLE at T+11 with sa_en=0 and busy=0; no done pulse; a new start at T+14 gives done at T+37.
REQ-035 rst_n driven low at T+8 for 2 cycles -> all outputs 0 immediately; no done afterward without a new start.
REQ-036 start in the DONE cycle (T+23) -> start_drop=1 at T+24, IDLE at T+24; start at T+25 gives done at T+48.
REQ-037 With TPU_CTRL_IRQ_EN: compute completes -> irq=1 from T+24; irq_clr at T+30 -> irq=0 at T+31; irq_clr coinciding with set -> irq stays 1.
